// File: rtl/io_ctrl.sv
// io_ctrl: memory-mapped IO controller with an LED register and a FIFO-buffered UART transmitter.
//   clk_i       system clock, all state on the rising edge
//   resetn_i    asynchronous active-low reset
//   io_addr_i   byte address; IO space when bit 22 is set, word address = bits [15:2]
//   io_wdata_i  store data
//   io_wr_i     one-cycle store strobe
//   io_rdata_o  combinational read data (OR of every selected register)
//   leds_o      LED register
//   uart_tx_o   serial TX line, idle high, 8N1 LSB first
module io_ctrl #(
    parameter int CLK_FREQ_HZ = 27000000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic [31:0] io_addr_i,
    input  logic [31:0] io_wdata_i,
    input  logic        io_wr_i,
    output logic [31:0] io_rdata_o,
    output logic [5:0]  leds_o,
    output logic        uart_tx_o
);
    localparam int DIV = CLK_FREQ_HZ / BAUD;
    localparam int CTW = $clog2(DIV);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam logic [CTW-1:0] BAUD_LAST = CTW'(DIV - 1);
    localparam logic [CW-1:0]  CNT_FULL  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         state_q;
    logic [CTW-1:0] baud_q;
    logic [2:0]     idx_q;
    logic [7:0]     shift_q;
    logic           uart_tx_q;
    logic [7:0]     mem_q [FIFO_DEPTH];
    logic [PW-1:0]  rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           ovf_q, ovf_d;
    logic [5:0]     leds_q, leds_d;

    logic        sel;
    logic [2:0]  wa;
    logic        wr_leds, wr_data, wr_cntl;
    logic        full, nonempty, push, pop, baud_done, busy;
    logic [31:0] status;
    logic        unused_bits;

    assign sel       = io_addr_i[22];
    assign wa        = io_addr_i[4:2];
    assign wr_leds   = io_wr_i & sel & wa[0];
    assign wr_data   = io_wr_i & sel & wa[1];
    assign wr_cntl   = io_wr_i & sel & wa[2];
    assign full      = count_q == CNT_FULL;
    assign nonempty  = count_q != '0;
    assign push      = wr_data & ~full;
    assign baud_done = baud_q == BAUD_LAST;
    // The FSM takes the next byte either from idle or at the end of a stop bit,
    // so back-to-back frames have no idle gap.
    assign pop       = nonempty & (state_q == IDLE || (state_q == STOP && baud_done));
    assign busy      = nonempty | (state_q != IDLE);
    assign status    = {21'b0, ovf_q, busy, full, 2'b0, 6'(count_q)};
    assign unused_bits = &{io_addr_i[31:23], io_addr_i[21:5], io_addr_i[1:0],
                           io_wdata_i[31:11], io_wdata_i[9:8]};

    assign io_rdata_o = sel ? (({32{wa[0]}} & {26'b0, leds_q}) | ({32{wa[1] | wa[2]}} & status)) : '0;
    assign leds_o     = leds_q;
    assign uart_tx_o  = uart_tx_q;

    always_comb begin
        rptr_d  = rptr_q + PW'(pop);
        wptr_d  = wptr_q + PW'(push);
        count_d = count_q + CW'(push) - CW'(pop);
        leds_d  = wr_leds ? io_wdata_i[5:0] : leds_q;
        // An overflow on the same edge wins over a clear request.
        ovf_d   = (wr_data & full) ? 1'b1 : (wr_cntl & io_wdata_i[10]) ? 1'b0 : ovf_q;
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            leds_q  <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            leds_q  <= leds_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= io_wdata_i[7:0];
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            uart_tx_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        shift_q   <= mem_q[rptr_q];
                        uart_tx_q <= 1'b0;
                        baud_q    <= '0;
                        state_q   <= START;
                    end
                end
                START: begin
                    if (baud_done) begin
                        uart_tx_q <= shift_q[0];
                        idx_q     <= '0;
                        baud_q    <= '0;
                        state_q   <= DATA;
                    end else begin
                        baud_q <= baud_q + CTW'(1);
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_q <= '0;
                        if (idx_q == 3'd7) begin
                            uart_tx_q <= 1'b1;
                            state_q   <= STOP;
                        end else begin
                            shift_q   <= {1'b0, shift_q[7:1]};
                            uart_tx_q <= shift_q[1];
                            idx_q     <= idx_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q + CTW'(1);
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud_q <= '0;
                        if (pop) begin
                            shift_q   <= mem_q[rptr_q];
                            uart_tx_q <= 1'b0;
                            state_q   <= START;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + CTW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
